mem_responder: RTL
==================

# mem_responder

Data-memory responder for the pipelined MIPS core's memory-stage port. It answers the core's `memwriteM`/`aluoutM`/`writedataM`/`readdataM` accesses with a word-addressed RAM and a small memory-mapped peripheral region. The peripheral region holds a console transmit FIFO, with a valid/ready drain port toward the testbench or UART, and a free-running cycle counter. It sits beside the core at the top level, in the place of a plain data memory.

## Interface
Parameters:
- `RAM_WORDS`, 64: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwriteM`  in  1  write strobe from the core's M stage.
- `aluoutM`  in  32  byte address from the core.
- `writedataM`  in  32  store data from the core.
- `readdataM`  out  32  load data; combinational from address and current state.
- `tx_data`  out  8  byte at the FIFO head.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head byte.

## Operation
- Address map (`aluoutM`; bits [1:0] ignored everywhere):
  - `0x0000_0000`..`4*RAM_WORDS-1` RAM: word index = `aluoutM[log2(RAM_WORDS)+1:2]`.
  - `0xFFFF_FF00` TX: a write pushes `writedataM[7:0]`. A read returns 0.
  - `0xFFFF_FF04` STATUS: a read returns `{29'b0, overflow, full, empty}`. Any write clears `overflow`.
  - `0xFFFF_FF08` CYCLES: a read returns the 32-bit counter. Writes are ignored.
  - Any other address: reads return 0 and writes are ignored.
- RAM: write on the rising edge when `memwriteM`=1. RAM is not reset; unwritten words read X.
- FIFO: circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Push is accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge.
  - A push that is refused drops the byte and sets the sticky `overflow`.
  - Pop happens on an edge where `tx_valid && tx_ready`.
- `tx_valid` = (count≠0). `tx_data` = entry at the read pointer. Both come straight from registers, with no combinational path from `tx_ready`.
- Simultaneous events on one edge:
  - Push+pop when full: both happen, count stays FIFO_DEPTH, and `overflow` is unchanged.
  - Push when empty: no pop that edge, because `tx_valid` was 0.
  - An `overflow` clear in the same cycle as a refused push cannot occur, since both target different addresses.
- CYCLES increments by 1 every edge while out of reset and wraps `0xFFFF_FFFF`→0.

## Timing
- Loads: zero latency. `readdataM` reflects the address in the same cycle and state as of the last edge, so a read of STATUS or CYCLES shows pre-edge values.
- Stores: take effect at the edge. A load from the same address in the next cycle returns the new value.
- Reset (`reset`=0) acts immediately, without waiting for `clk`:
  - FIFO count, pointers and `overflow` go to 0 and CYCLES goes to 0.
  - `tx_valid`=0. `tx_data` is don't-care.
  - STATUS reads `0x0000_0001`.
  - Asserting reset mid-drain discards all queued bytes.
- After deassertion, CYCLES reads 1 after the first edge and N after the Nth edge.
- A byte pushed at edge k is visible on `tx_valid`/`tx_data` from edge k onward and can be popped at edge k+1 at the earliest.
- Byte order out of the FIFO is strict FIFO order.

## Test plan
- RAM: store `0xDEADBEEF` to `0x10`, then load `0x10` and `0x13` → both return `0xDEADBEEF`. Loading `0x14` is unaffected.
- Console drain: push `0x41` and `0x42` with `tx_ready`=0 → `tx_valid`=1, `tx_data`=`0x41`, STATUS=`0x0`. Raise `tx_ready` → `0x41` is popped at the first edge and `0x42` at the second, then `tx_valid`=0 and STATUS=`0x1`.
- Overflow (FIFO_DEPTH=4): push 5 bytes `0x01`..`0x05` with `tx_ready`=0 → STATUS=`0x6`. Draining yields `0x01`..`0x04` only. A write to STATUS then leaves STATUS=`0x1`.
- Full with simultaneous push and pop: fill with `0x01`..`0x04`, then push `0x09` on the same edge that pops `0x01` → STATUS=`0x2`, `overflow`=0, and the drain order is `0x02,0x03,0x04,0x09`.
- Reset mid-operation: queue 3 bytes, then pull `reset` low between clock edges → `tx_valid` falls immediately. After release, STATUS=`0x1` and CYCLES reads 1 after the first edge.
- Unmapped and CYCLES: a load from `0x8000_0000` returns 0. Two loads of CYCLES 10 edges apart differ by exactly 10.

Source files
------------

// File: rtl/mem_responder.sv
// Data-memory responder for the MIPS M stage: word RAM plus a console TX FIFO,
// a FIFO status register and a free-running cycle counter mapped at 0xFFFF_FF00.
module mem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [29:0]   TX_WA    = 30'h3FFF_FFC0;
    localparam logic [29:0]   ST_WA    = 30'h3FFF_FFC1;
    localparam logic [29:0]   CY_WA    = 30'h3FFF_FFC2;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   cycles_q, cycles_d;

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          in_ram, is_tx, is_st, is_cy;
    logic          full, empty, push_req, push_ok, pop;
    logic          unused_addr_bits;

    // Byte-lane bits never select anything; all decodes work on word addresses.
    assign unused_addr_bits = ^aluoutM[1:0];
    assign word_addr = aluoutM[31:2];
    assign ram_idx   = word_addr[AW-1:0];
    assign in_ram    = (word_addr[29:AW] == '0);
    assign is_tx     = (word_addr == TX_WA);
    assign is_st     = (word_addr == ST_WA);
    assign is_cy     = (word_addr == CY_WA);

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_q[rd_ptr_q];
    assign pop      = tx_valid && tx_ready;
    assign push_req = memwriteM && is_tx;
    // A pop on the same edge frees the slot, so a full FIFO still takes the byte.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cycles_d   = cycles_q + 32'd1;
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok)
            wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (memwriteM && is_st)
            overflow_d = 1'b0;
        else if (push_req && !push_ok)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cycles_q   <= cycles_d;
        end
    end

    // Storage arrays carry no reset; FIFO contents are only visible through count.
    always_ff @(posedge clk) begin
        if (memwriteM && in_ram)
            ram_q[ram_idx] <= writedataM;
        if (push_ok)
            fifo_q[wr_ptr_q] <= writedataM[7:0];
    end

    always_comb begin
        readdataM = 32'd0;
        if (in_ram)
            readdataM = ram_q[ram_idx];
        else if (is_st)
            readdataM = {29'd0, overflow_q, full, empty};
        else if (is_cy)
            readdataM = cycles_q;
    end

endmodule
